// File: rtl/writeback_queue_if.sv
// Handshake, write-port and forwarding signals between the completion logic,
// the writeback queue and the register file.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          ctrl_stall;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [4:0]    ctrl_readRegA;
    logic [4:0]    ctrl_readRegB;
    logic          fwd_hitA;
    logic [31:0]   fwd_dataA;
    logic          fwd_hitB;
    logic [31:0]   fwd_dataB;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_reg, in_data, ctrl_stall, ctrl_readRegA, ctrl_readRegB,
        input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, ctrl_stall, ctrl_readRegA, ctrl_readRegB,
        output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback buffer draining one result per cycle into the register
// file write port, with youngest-entry forwarding to both read ports.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic               clock,
    input logic               ctrl_reset,
    writeback_queue_if.slave  wb
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]    reg_mem_q  [DEPTH];
    logic [4:0]    reg_mem_d  [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ready;
    logic          write_en;
    logic          store;
    logic          hit_a, hit_b;
    logic [31:0]   fwd_a, fwd_b;

    assign ready    = count_q < CW'(DEPTH);
    assign write_en = (count_q != '0) && !wb.ctrl_stall;
    // Register 0 completes the handshake but is never queued.
    assign store    = wb.in_valid && ready && (wb.in_reg != 5'd0);

    assign wb.in_ready         = ready;
    assign wb.ctrl_writeEnable = write_en;
    assign wb.ctrl_writeReg    = (count_q != '0) ? reg_mem_q[head_q]  : 5'd0;
    assign wb.data_writeReg    = (count_q != '0) ? data_mem_q[head_q] : 32'd0;
    assign wb.count            = count_q;
    assign wb.fwd_hitA         = hit_a;
    assign wb.fwd_dataA        = fwd_a;
    assign wb.fwd_hitB         = hit_b;
    assign wb.fwd_dataB        = fwd_b;

    always_comb begin
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (store) begin
            reg_mem_d[tail_q]  = wb.in_reg;
            data_mem_d[tail_q] = wb.in_data;
            tail_d             = tail_q + PW'(1);
        end
        if (write_en) begin
            head_d = head_q + PW'(1);
        end
        case ({store, write_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = 32'd0;
        fwd_b = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (wb.ctrl_readRegA != 5'd0 && reg_mem_q[idx] == wb.ctrl_readRegA) begin
                    hit_a = 1'b1;
                    fwd_a = data_mem_q[idx];
                end
                if (wb.ctrl_readRegB != 5'd0 && reg_mem_q[idx] == wb.ctrl_readRegB) begin
                    hit_b = 1'b1;
                    fwd_b = data_mem_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            reg_mem_q  <= reg_mem_d;
            data_mem_q <= data_mem_d;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed vector table plus hand sequences for wrap and mid-cycle reset.
module tb_writeback_queue;
    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    always #5 clock = ~clock;

    writeback_queue_if #(.DEPTH(4)) wb ();
    writeback_queue #(.DEPTH(4)) dut (.clock(clock), .ctrl_reset(ctrl_reset), .wb(wb.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;   logic [4:0] r;  logic [31:0] d;  logic st;
        logic [4:0]  ra;  logic [4:0] rb;
        logic        rdy; logic we;       logic [4:0]  wr; logic [31:0] wd;
        logic        ha;  logic [31:0] da; logic hb;       logic [31:0] db;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic v, input logic [4:0] r, input logic [31:0] d,
                                input logic st, input logic [4:0] ra, input logic [4:0] rb,
                                input logic rdy, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic ha, input logic [31:0] da,
                                input logic hb, input logic [31:0] db, input logic [2:0] cnt);
        vec_t x;
        x.v = v; x.r = r; x.d = d; x.st = st; x.ra = ra; x.rb = rb;
        x.rdy = rdy; x.we = we; x.wr = wr; x.wd = wd;
        x.ha = ha; x.da = da; x.hb = hb; x.db = db; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic st, input logic [4:0] ra, input logic [4:0] rb);
        wb.in_valid = v; wb.in_reg = r; wb.in_data = d;
        wb.ctrl_stall = st; wb.ctrl_readRegA = ra; wb.ctrl_readRegB = rb;
    endtask

    task automatic chk_all(input string p, input vec_t e);
        chk({p, ".rdy"},   32'(wb.in_ready),         32'(e.rdy));
        chk({p, ".we"},    32'(wb.ctrl_writeEnable), 32'(e.we));
        chk({p, ".wreg"},  32'(wb.ctrl_writeReg),    32'(e.wr));
        chk({p, ".wdata"}, wb.data_writeReg,         e.wd);
        chk({p, ".hitA"},  32'(wb.fwd_hitA),         32'(e.ha));
        chk({p, ".dataA"}, wb.fwd_dataA,             e.da);
        chk({p, ".hitB"},  32'(wb.fwd_hitB),         32'(e.hb));
        chk({p, ".dataB"}, wb.fwd_dataB,             e.db);
        chk({p, ".cnt"},   32'(wb.count),            32'(e.cnt));
    endtask

    logic [4:0]  q_r [$];
    logic [31:0] q_d [$];

    initial begin
        int pushed, written, cyc;
        logic st, exp_rdy, exp_we;

        //        v  r   d        st ra  rb   rdy we wr  wd       ha da       hb db     cnt
        tbl[0]  = mk(1, 5,  32'hAA,  0, 5,  0,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[1]  = mk(0, 0,  32'h0,   0, 5,  0,   1, 1, 5,  32'hAA,  1, 32'hAA,  0, 32'h0, 1);
        tbl[2]  = mk(0, 0,  32'h0,   0, 5,  0,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[3]  = mk(1, 1,  32'h11,  1, 0,  0,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[4]  = mk(1, 2,  32'h22,  1, 0,  0,   1, 0, 1,  32'h11,  0, 32'h0,   0, 32'h0, 1);
        tbl[5]  = mk(1, 3,  32'h33,  1, 0,  0,   1, 0, 1,  32'h11,  0, 32'h0,   0, 32'h0, 2);
        tbl[6]  = mk(1, 4,  32'h44,  1, 0,  0,   1, 0, 1,  32'h11,  0, 32'h0,   0, 32'h0, 3);
        tbl[7]  = mk(1, 9,  32'h99,  1, 0,  0,   0, 0, 1,  32'h11,  0, 32'h0,   0, 32'h0, 4);
        tbl[8]  = mk(1, 10, 32'hA0,  0, 4,  9,   0, 1, 1,  32'h11,  1, 32'h44,  0, 32'h0, 4);
        tbl[9]  = mk(0, 0,  32'h0,   0, 4,  9,   1, 1, 2,  32'h22,  1, 32'h44,  0, 32'h0, 3);
        tbl[10] = mk(0, 0,  32'h0,   0, 4,  9,   1, 1, 3,  32'h33,  1, 32'h44,  0, 32'h0, 2);
        tbl[11] = mk(0, 0,  32'h0,   0, 4,  9,   1, 1, 4,  32'h44,  1, 32'h44,  0, 32'h0, 1);
        tbl[12] = mk(0, 0,  32'h0,   0, 4,  9,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[13] = mk(1, 7,  32'h100, 1, 7,  8,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[14] = mk(1, 7,  32'h200, 1, 7,  8,   1, 0, 7,  32'h100, 1, 32'h100, 0, 32'h0, 1);
        tbl[15] = mk(0, 0,  32'h0,   1, 7,  8,   1, 0, 7,  32'h100, 1, 32'h200, 0, 32'h0, 2);
        tbl[16] = mk(0, 0,  32'h0,   0, 7,  8,   1, 1, 7,  32'h100, 1, 32'h200, 0, 32'h0, 2);
        tbl[17] = mk(0, 0,  32'h0,   0, 7,  8,   1, 1, 7,  32'h200, 1, 32'h200, 0, 32'h0, 1);
        tbl[18] = mk(0, 0,  32'h0,   0, 7,  8,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[19] = mk(1, 0,  32'hDEAD,0, 0,  3,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[20] = mk(1, 3,  32'h33,  0, 0,  3,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);
        tbl[21] = mk(0, 0,  32'h0,   0, 0,  3,   1, 1, 3,  32'h33,  0, 32'h0,   1, 32'h33, 1);
        tbl[22] = mk(0, 0,  32'h0,   0, 0,  3,   1, 0, 0,  32'h0,   0, 32'h0,   0, 32'h0, 0);

        drive(0, 0, 0, 0, 5, 0);
        #12;
        chk_all("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        ctrl_reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clock);
            drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].st, tbl[i].ra, tbl[i].rb);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Back-to-back pushes against a toggling stall; producer holds until accepted.
        pushed = 0; written = 0; cyc = 0;
        while ((pushed < 10 || q_r.size() != 0) && cyc < 80) begin
            @(negedge clock);
            st = (cyc % 2 == 0);
            cyc++;
            drive(pushed < 10, 5'(16 + pushed), 32'hC000 + 32'(pushed), st, 0, 0);
            #1;
            exp_rdy = (q_r.size() < 4);
            exp_we  = (q_r.size() != 0) && !st;
            chk("wrap.rdy", 32'(wb.in_ready), 32'(exp_rdy));
            chk("wrap.cnt", 32'(wb.count), q_r.size());
            chk("wrap.we",  32'(wb.ctrl_writeEnable), 32'(exp_we));
            if (exp_we) begin
                chk("wrap.wreg",  32'(wb.ctrl_writeReg), 32'(q_r[0]));
                chk("wrap.wdata", wb.data_writeReg, q_d[0]);
                void'(q_r.pop_front());
                void'(q_d.pop_front());
                written++;
            end
            if (pushed < 10 && exp_rdy) begin
                q_r.push_back(5'(16 + pushed));
                q_d.push_back(32'hC000 + 32'(pushed));
                pushed++;
            end
        end
        chk("wrap.written", written, 10);

        // Reset between edges with three entries pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1, 5'(12 + i), 32'hE1 + 32'(i), 1, 0, 0);
        end
        @(negedge clock);
        drive(0, 0, 0, 1, 12, 14);
        #1;
        chk("rst.pre_cnt",  32'(wb.count), 3);
        chk("rst.pre_hitA", 32'(wb.fwd_hitA), 1);
        #1;
        ctrl_reset = 1'b1;
        wb.ctrl_stall = 1'b0;
        #1;
        chk_all("rst.mid", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            chk("rst.post_we",   32'(wb.ctrl_writeEnable), 0);
            chk("rst.post_cnt",  32'(wb.count), 0);
            chk("rst.post_hitA", 32'(wb.fwd_hitA), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register writeback results from execution units and drains them, one per cycle, into the register file's single write port. Pending entries are forwarded to the two register-file read ports so that decode never reads a stale value. The block sits between the execute/multdiv completion logic and the register file. It drives the register file's write port directly: ctrl_writeEnable, ctrl_writeReg and data_writeReg.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- CW, $clog2(DEPTH+1): width of occupancy output.

Ports:
- clock  in  1  rising-edge clock.
- ctrl_reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer presents a result.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_reg  in  5  destination register.
- in_data  in  32  result value.
- ctrl_stall  in  1  write port unavailable this cycle; suppresses drain.
- ctrl_writeEnable  out  1  write strobe to register file.
- ctrl_writeReg  out  5  register-file write address (head entry).
- data_writeReg  out  32  register-file write data (head entry).
- ctrl_readRegA  in  5  read address A, snooped for forwarding.
- ctrl_readRegB  in  5  read address B, snooped for forwarding.
- fwd_hitA  out  1  a pending entry targets ctrl_readRegA.
- fwd_dataA  out  32  data of youngest matching entry for A, else 0.
- fwd_hitB  out  1  a pending entry targets ctrl_readRegB.
- fwd_dataB  out  32  data of youngest matching entry for B, else 0.
- count  out  CW  entries currently held.

## Operation
- Storage: circular buffer of DEPTH entries {reg[4:0], data[31:0]} with head/tail pointers (log2 DEPTH bits, natural wrap) and an occupancy counter.
- Push: in_valid && in_ready at a rising edge writes the entry at tail, advances tail, and increments count.
- Register 0: in_valid && in_ready with in_reg == 0 is accepted (handshake completes) but nothing is stored; tail and count are unchanged.
- Drain: ctrl_writeEnable = (count != 0) && !ctrl_stall, combinational from stored state and ctrl_stall.
  - ctrl_writeReg and data_writeReg show the head entry whenever count != 0, otherwise 0.
  - A rising edge with ctrl_writeEnable high pops the head: head advances, count decrements.
- Push and pop on the same edge: both take effect and count is unchanged. When the queue is empty there is no pass-through; the new entry drains on a later cycle.
- Full: in_ready is low and in_valid is ignored. A pop on the same edge does not raise in_ready within that cycle.
- Forwarding, checked per port X in {A, B}:
  - fwd_hitX = 1 when ctrl_readRegX != 0 and any valid entry has reg == ctrl_readRegX.
  - fwd_dataX is the data of the youngest such entry (closest to tail).
  - The head entry being written this cycle still counts as a hit. This covers the cycle where the register file returns high-Z for a same-address read during a write.
  - Forwarding is purely combinational and does not look at in_valid/in_data.
- Multiple entries to the same register are written in order. The last one wins in the register file and in forwarding.

## Timing
- Reset (asynchronous, immediate): all entries are invalidated, pointers and count go to 0. Resulting outputs: in_ready=1, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, fwd_hitA/B=0, fwd_dataA/B=0, count=0.
- Reset asserted mid-operation discards all pending entries; no partial write is issued after ctrl_reset rises.
- Latency, empty queue with ctrl_stall=0:
  - Accepted at edge N, the entry is presented with ctrl_writeEnable=1 during cycle N→N+1.
  - The register file captures it at edge N+1.
  - fwd_hit asserts from edge N until edge N+1.
- Throughput: one push and one pop per cycle. With ctrl_stall low and one push per cycle, the queue never exceeds 1 entry.
- ctrl_stall high holds head, pointers and outputs stable, with ctrl_writeEnable=0. Pushes continue until full.

## Test plan
- Reset and single write:
  - Stimulus: after reset, push (reg 5, 0x0000_00AA) at edge 1.
  - Required: count=1 and ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xAA during cycle 1→2; count=0 after edge 2; in_ready high throughout.
- Stall to full:
  - Stimulus: ctrl_stall=1, push regs 1, 2, 3, 4 with data 0x11, 0x22, 0x33, 0x44.
  - Required: count=4, in_ready=0, a 5th push is ignored. Releasing the stall drains 1, 2, 3, 4 in order on four consecutive cycles; count steps 3, 2, 1, 0.
- Forwarding youngest:
  - Stimulus: ctrl_stall=1, push (7, 0x100) then (7, 0x200); set ctrl_readRegA=7, ctrl_readRegB=8.
  - Required: fwd_hitA=1, fwd_dataA=0x200, fwd_hitB=0, fwd_dataB=0. After both entries drain, fwd_hitA=0.
- Register 0 drop:
  - Stimulus: push (0, 0xDEAD) followed by (3, 0x33).
  - Required: in_ready=1 on both; only reg 3 is ever written; count never exceeds 1; a read of address 0 never hits.
- Simultaneous push/pop and wrap:
  - Stimulus: with DEPTH=4, stream 10 back-to-back pushes while ctrl_stall toggles 1, 0, 1, 0, ...
  - Required: every write issues in push order with correct data across pointer wrap; count is never greater than 4 and never negative.
- Reset mid-operation:
  - Stimulus: 3 entries pending with ctrl_stall=1, then assert ctrl_reset between clock edges.
  - Required: outputs go to reset values immediately; after release, no stale entry is ever written and count=0.
